// File: rtl/tpu_pkg.sv
// Shared definitions for the convolution engine slice.
// Holds the sequencer state encoding and the index widths for the default
// 16x16 matrix / 3x3 kernel build. Modules with other parameter values
// derive their own widths from their parameters.
package tpu_pkg;

  localparam int unsigned MATRIX_DIM_DEF = 16;
  localparam int unsigned CONV_DIM_DEF   = 3;

  localparam int unsigned OUT_DIM = MATRIX_DIM_DEF - CONV_DIM_DEF + 1;
  localparam int unsigned MIW     = $clog2(MATRIX_DIM_DEF * MATRIX_DIM_DEF);
  localparam int unsigned KIW     = $clog2(CONV_DIM_DEF * CONV_DIM_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    LOAD_M,
    CLR,
    ACC,
    CAP,
    OUT,
    FIN
  } state_e;

endpackage

// File: rtl/idx2d_counter.sv
// Two-dimensional row/column counter.
// The column advances on every enable; after COLS-1 it returns to 0 and the
// row advances. After (ROWS-1, COLS-1) the whole counter returns to (0, 0).
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clr_i     synchronous clear to (0, 0)
//   en_i      advance one position
//   row_o     current row
//   col_o     current column
//   wrap_o    counter sits on its final position (next enable wraps to 0,0)
module idx2d_counter #(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3,
  parameter int unsigned W    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] row_o,
  output logic [W-1:0] col_o,
  output logic         wrap_o
);

  logic [W-1:0] row_q, row_d;
  logic [W-1:0] col_q, col_d;
  logic         row_end, col_end;

  assign row_end = (row_q == W'(ROWS - 1));
  assign col_end = (col_q == W'(COLS - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign wrap_o = row_end & col_end;

endmodule

// File: rtl/conv_sequencer.sv
// Convolution engine sequencer.
// Accepts one host byte stream (kernel, then matrix), steers it into the
// kernel/matrix register files, then steps the MAC over every valid window
// (CONV_DIM^2 accumulate cycles each) and hands each window result out over
// a valid/ready port.
// Configuration macro: KERNEL_REUSE_EN -- when defined, start with
// keep_kernel skips the kernel load and reuses the stored kernel.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, keep_kernel    job start (IDLE only) / skip kernel load
//   in_valid, in_ready    host byte handshake
//   krn_we, mat_we        register file write strobes
//   wr_idx                flat write index
//   rd_kidx, rd_midx      flat kernel / matrix read indices
//   mac_clr, mac_en       MAC control
//   mac_sum               MAC accumulator value
//   out_valid, out_ready  result handshake
//   out_data, out_last    window result, final-window flag
//   busy, done            job in progress, job-complete pulse
module conv_sequencer #(
  parameter  int unsigned MATRIX_DIM = tpu_pkg::MATRIX_DIM_DEF,
  parameter  int unsigned CONV_DIM   = tpu_pkg::CONV_DIM_DEF,
  localparam int unsigned MIW        = $clog2(MATRIX_DIM * MATRIX_DIM),
  localparam int unsigned KIW        = $clog2(CONV_DIM * CONV_DIM)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           keep_kernel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           krn_we,
  output logic           mat_we,
  output logic [MIW-1:0] wr_idx,
  output logic [KIW-1:0] rd_kidx,
  output logic [MIW-1:0] rd_midx,
  output logic           mac_clr,
  output logic           mac_en,
  input  logic [7:0]     mac_sum,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_data,
  output logic           out_last,
  output logic           busy,
  output logic           done
);
  import tpu_pkg::*;

  localparam int unsigned ODIM = MATRIX_DIM - CONV_DIM + 1;
  localparam int unsigned KN   = CONV_DIM * CONV_DIM;
  localparam int unsigned MN   = MATRIX_DIM * MATRIX_DIM;
  localparam int unsigned CW   = $clog2(MATRIX_DIM);

  state_e         state_q, state_d;
  logic [MIW-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]     out_data_q;
  logic [CW-1:0]  kr, kc, wr, wc;
  logic           k_last, w_last;
  logic           k_en, w_en, idle;

  assign idle = (state_q == IDLE);

  idx2d_counter #(.ROWS(CONV_DIM), .COLS(CONV_DIM), .W(CW)) u_kcnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (idle),
    .en_i   (k_en),
    .row_o  (kr),
    .col_o  (kc),
    .wrap_o (k_last)
  );

  idx2d_counter #(.ROWS(ODIM), .COLS(ODIM), .W(CW)) u_wcnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (idle),
    .en_i   (w_en),
    .row_o  (wr),
    .col_o  (wc),
    .wrap_o (w_last)
  );

`ifndef KERNEL_REUSE_EN
  logic unused_keep;
  assign unused_keep = keep_kernel;
`endif

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    in_ready  = 1'b0;
    krn_we    = 1'b0;
    mat_we    = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    k_en      = 1'b0;
    w_en      = 1'b0;
    busy      = !idle;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef KERNEL_REUSE_EN
          state_d = keep_kernel ? LOAD_M : LOAD_K;
`else
          state_d = LOAD_K;
`endif
        end
      end
      LOAD_K: begin
        in_ready = 1'b1;
        krn_we   = in_valid;
        if (in_valid) begin
          if (wr_idx_q == MIW'(KN - 1)) begin
            wr_idx_d = '0;
            state_d  = LOAD_M;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      LOAD_M: begin
        in_ready = 1'b1;
        mat_we   = in_valid;
        if (in_valid) begin
          if (wr_idx_q == MIW'(MN - 1)) begin
            wr_idx_d = '0;
            state_d  = CLR;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      CLR: begin
        mac_clr = 1'b1;
        state_d = ACC;
      end
      ACC: begin
        mac_en = 1'b1;
        k_en   = 1'b1;
        if (k_last) state_d = CAP;
      end
      CAP: state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        out_last  = w_last;
        if (out_ready) begin
          w_en    = 1'b1;
          state_d = w_last ? FIN : CLR;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // CAP exists so the MAC register has absorbed the final product before capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_idx_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      if (state_q == CAP) out_data_q <= mac_sum;
    end
  end

  assign wr_idx   = wr_idx_q;
  assign out_data = out_data_q;
  assign rd_kidx  = KIW'(32'(kr) * CONV_DIM + 32'(kc));
  assign rd_midx  = MIW'((32'(wr) + 32'(kr)) * MATRIX_DIM + 32'(wc) + 32'(kc));

endmodule

// File: tb/tb_conv_sequencer.sv
module tb_conv_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, keep_kernel, in_valid, out_ready;
  logic       in_ready, krn_we, mat_we, mac_clr, mac_en;
  logic       out_valid, out_last, busy, done;
  logic [7:0] wr_idx, rd_midx, out_data, mac_sum, in_data;
  logic [3:0] rd_kidx;

  conv_sequencer #(.MATRIX_DIM(16), .CONV_DIM(3)) dut (
    .clk(clk), .rst(rst), .start(start), .keep_kernel(keep_kernel),
    .in_valid(in_valid), .in_ready(in_ready), .krn_we(krn_we), .mat_we(mat_we),
    .wr_idx(wr_idx), .rd_kidx(rd_kidx), .rd_midx(rd_midx),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_sum(mac_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: register files and an 8-bit wrapping MAC.
  logic [7:0] kmem [0:15];
  logic [7:0] mmem [0:255];
  logic [7:0] acc_q = '0;
  assign mac_sum = acc_q;
  always @(posedge clk) begin
    if (krn_we) kmem[wr_idx] <= in_data;
    if (mat_we) mmem[wr_idx] <= in_data;
    if (mac_clr)     acc_q <= '0;
    else if (mac_en) acc_q <= acc_q + kmem[rd_kidx] * mmem[rd_midx];
  end

  logic [7:0] kern [0:8];
  logic [7:0] mat  [0:255];
  logic [8:0] sb [$];
  int n_pass = 0, n_total = 0;
  int kw_cnt = 0, mw_cnt = 0, n_acc = 0;
  bit done_seen = 0, done_exp = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({in_ready, krn_we, mat_we, wr_idx, rd_kidx, rd_midx, mac_clr, mac_en,
                out_valid, out_data, out_last, busy, done});
  endfunction

  task automatic build_expected();
    sb.delete();
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++) begin
        int s = 0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            s += int'(kern[kr*3+kc]) * int'(mat[(r+kr)*16 + c + kc]);
        sb.push_back({(r == 13 && c == 13), s[7:0]});
      end
  endtask

  // Monitor: write-index sequencing, scoreboard pops, done pulse timing.
  always @(negedge clk) begin
    if (rst) begin
      done_exp = 0;
    end else begin
      if (done_exp || done) check("done_pulse", done, done_exp);
      done_exp = 0;
      if (done) done_seen = 1;
      if (krn_we) begin check("krn_wr_idx", wr_idx, kw_cnt); kw_cnt++; end
      if (mat_we) begin check("mat_wr_idx", wr_idx, mw_cnt); mw_cnt++; end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
        else begin
          logic [8:0] e;
          e = sb.pop_front();
          check("out_data", out_data, e[7:0]);
          check("out_last", out_last, e[8]);
          n_acc++;
          if (e[8]) done_exp = 1;
        end
      end
    end
  end

  task automatic send(input int n, input bit is_k, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) while ($urandom_range(0, 1) == 1) begin
        in_valid = 0; in_data = 8'hEE; @(posedge clk); #1;
      end
      in_data = is_k ? kern[i] : mat[i];
      in_valid = 1; @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic pulse_start(input bit keep);
    keep_kernel = keep; start = 1; @(posedge clk); #1;
    start = 0; keep_kernel = 0;
  endtask

  task automatic run_job(input bit keep, input bit rnd, input bit stall, input bit poke);
    bit load_k, got;
    logic [7:0]  d0;
    logic [11:0] idx0;
    load_k = 1'b1;
`ifdef KERNEL_REUSE_EN
    if (keep) load_k = 1'b0;
`endif
    kw_cnt = 0; mw_cnt = 0; n_acc = 0; done_seen = 0;
    build_expected();
    out_ready = !stall;
    pulse_start(keep);
    check("busy_start", busy, 1);
    check("in_ready_load", in_ready, 1);
    if (load_k) send(9, 1, rnd);
    send(256, 0, rnd);
    if (stall) begin
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = out_valid; end
      check("stall_reach", got, 1);
      d0 = out_data; idx0 = {rd_midx, rd_kidx};
      repeat (5) begin
        @(negedge clk);
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, d0);
        check("stall_mac", {mac_clr, mac_en}, 2'b00);
        check("stall_idx", {rd_midx, rd_kidx}, idx0);
      end
      @(posedge clk); #1; out_ready = 1;
    end
    if (poke) begin
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = mac_en; end
      check("poke_reach", got, 1);
      @(posedge clk); #1; start = 1; in_valid = 1; in_data = 8'h55;
      @(posedge clk); #1; start = 0; in_valid = 0;
      check("poke_busy", busy, 1);
    end
    for (int i = 0; i < 20000 && !done_seen; i++) @(negedge clk);
    check("job_done", done_seen, 1);
    @(negedge clk);
    check("krn_writes", kw_cnt, load_k ? 9 : 0);
    check("mat_writes", mw_cnt, 256);
    check("results", n_acc, 196);
    check("sb_drained", sb.size(), 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    bit got;
    rst = 1; start = 0; keep_kernel = 0; in_valid = 0; in_data = '0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 0);
    rst = 0;

    // all-ones kernel and matrix: every window sums to 9
    foreach (kern[i]) kern[i] = 8'd1;
    foreach (mat[i])  mat[i]  = 8'd1;
    run_job(0, 0, 0, 0);

    // centre-only kernel, ramp matrix, random in_valid gaps, stalled window 0
    foreach (kern[i]) kern[i] = (i == 4) ? 8'd1 : 8'd0;
    foreach (mat[i])  mat[i]  = 8'(i);
    run_job(0, 1, 1, 0);

    // 0xFF everywhere wraps to 9; start and in_valid pokes mid-job are ignored
    foreach (kern[i]) kern[i] = 8'hFF;
    foreach (mat[i])  mat[i]  = 8'hFF;
    run_job(0, 0, 0, 1);

    // reset during ACC of window 7
    foreach (kern[i]) kern[i] = 8'd1;
    foreach (mat[i])  mat[i]  = 8'd1;
    kw_cnt = 0; mw_cnt = 0; n_acc = 0; done_seen = 0;
    build_expected();
    pulse_start(0);
    send(9, 1, 0);
    send(256, 0, 0);
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin @(negedge clk); got = (n_acc == 7) && mac_en; end
    check("rst_reach", got, 1);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_outs", outs(), 0);
    sb.delete();
    rst = 0;

    // fresh job after abort
    foreach (kern[i]) kern[i] = (i == 4) ? 8'd1 : 8'd0;
    foreach (mat[i])  mat[i]  = 8'(i);
    run_job(0, 0, 0, 0);

    // keep_kernel job: matrix only with reuse, full load otherwise
    foreach (mat[i]) mat[i] = 8'(255 - i);
    run_job(1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
